// File: rtl/cfg_frame_loader.sv
// Purpose: assembles configuration frames from a word stream and fires one latch-enable strobe per frame.
// Latency: strobe and FrameData are valid the cycle after the last data word of a frame is accepted.
// Backpressure: WordReady drops for exactly the one strobe cycle per frame; WordValid gaps simply stall the FSM.
module cfg_frame_loader #(
    parameter int WORD_WIDTH        = 32,
    parameter int NUM_ROWS          = 4,
    parameter int NUM_COLUMNS       = 8,
    parameter int FRAMES_PER_COLUMN = 20,
    parameter logic [WORD_WIDTH-1:0] SYNC_WORD   = 32'hFAB0_FAB1,
    parameter logic [WORD_WIDTH-1:0] DESYNC_WORD = 32'hFAB0_DE5C
) (
    input  logic                                       CLK,
    input  logic                                       RESET,
    input  logic [WORD_WIDTH-1:0]                      WordData,
    input  logic                                       WordValid,
    output logic                                       WordReady,
    output logic [NUM_ROWS*WORD_WIDTH-1:0]             FrameData,
    output logic [NUM_COLUMNS*FRAMES_PER_COLUMN-1:0]   FrameStrobe,
    output logic                                       ConfigActive,
    output logic [15:0]                                FrameCount,
    output logic                                       Error
);

    localparam int STROBE_W = NUM_COLUMNS * FRAMES_PER_COLUMN;
    localparam int ROW_W    = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

    typedef enum logic [1:0] {IDLE, HDR, DATA, STROBE} state_t;

    state_t             state;
    logic [ROW_W-1:0]   row_cnt;
    logic [7:0]         col_q;
    logic [7:0]         frm_q;
    logic               frame_bad;

    logic               accept;
    logic [7:0]         hdr_col;
    logic [7:0]         hdr_frm;
    logic               hdr_bad;
    logic [31:0]        strobe_idx;
    logic [STROBE_W-1:0] strobe_next;

    // Handshake qualification, header field decode and one-hot strobe pattern for the latched header.
    always_comb begin
        accept      = WordValid & WordReady;
        hdr_col     = WordData[15:8];
        hdr_frm     = WordData[7:0];
        hdr_bad     = (32'(hdr_col) >= 32'(NUM_COLUMNS)) ||
                      (32'(hdr_frm) >= 32'(FRAMES_PER_COLUMN));
        strobe_idx  = 32'(col_q) * 32'(FRAMES_PER_COLUMN) + 32'(frm_q);
        strobe_next = STROBE_W'(1) << strobe_idx;
    end

    // Loader FSM; every output is a register so the latch enables never glitch.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= IDLE;
            WordReady    <= 1'b1;
            FrameData    <= '0;
            FrameStrobe  <= '0;
            FrameCount   <= '0;
            Error        <= 1'b0;
            ConfigActive <= 1'b0;
            row_cnt      <= '0;
            col_q        <= '0;
            frm_q        <= '0;
            frame_bad    <= 1'b0;
        end else begin
            FrameStrobe <= '0;
            case (state)
                IDLE: begin
                    // Anything but the sync word is dropped before configuration mode.
                    if (accept && WordData == SYNC_WORD) begin
                        state        <= HDR;
                        FrameCount   <= '0;
                        Error        <= 1'b0;
                        ConfigActive <= 1'b1;
                    end
                end
                HDR: begin
                    if (accept) begin
                        if (WordData == DESYNC_WORD) begin
                            state        <= IDLE;
                            ConfigActive <= 1'b0;
                        end else begin
                            // A bad header still consumes its data words to keep the stream aligned.
                            col_q     <= hdr_col;
                            frm_q     <= hdr_frm;
                            frame_bad <= hdr_bad;
                            if (hdr_bad) begin
                                Error <= 1'b1;
                            end
                            row_cnt <= '0;
                            state   <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        FrameData[row_cnt*WORD_WIDTH +: WORD_WIDTH] <= WordData;
                        if (row_cnt == LAST_ROW) begin
                            row_cnt <= '0;
                            if (frame_bad) begin
                                state <= HDR;
                            end else begin
                                state       <= STROBE;
                                WordReady   <= 1'b0;
                                FrameStrobe <= strobe_next;
                                if (FrameCount != 16'hFFFF) begin
                                    FrameCount <= FrameCount + 16'd1;
                                end
                            end
                        end else begin
                            row_cnt <= row_cnt + ROW_W'(1);
                        end
                    end
                end
                STROBE: begin
                    state     <= HDR;
                    WordReady <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cfg_frame_loader.sv
// Purpose: directed self-checking bench for cfg_frame_loader at default parameters.
// Latency: expects strobe/FrameData one cycle after the last data word is accepted.
// Backpressure: exercises WordValid stalls and the single WordReady-low cycle per frame.
module tb_cfg_frame_loader;

    localparam logic [31:0] SYNC   = 32'hFAB0_FAB1;
    localparam logic [31:0] DESYNC = 32'hFAB0_DE5C;

    logic          CLK = 1'b0;
    logic          RESET;
    logic [31:0]   WordData;
    logic          WordValid;
    logic          WordReady;
    logic [127:0]  FrameData;
    logic [159:0]  FrameStrobe;
    logic          ConfigActive;
    logic [15:0]   FrameCount;
    logic          Error;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int strobe_cycles = 0;
    int ready_low = 0;
    int not_onehot = 0;
    int run = 0;
    int max_run = 0;

    cfg_frame_loader dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .WordData     (WordData),
        .WordValid    (WordValid),
        .WordReady    (WordReady),
        .FrameData    (FrameData),
        .FrameStrobe  (FrameStrobe),
        .ConfigActive (ConfigActive),
        .FrameCount   (FrameCount),
        .Error        (Error)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Observe strobe shape and ready drops mid-cycle, away from the active edge.
    always @(negedge CLK) begin
        if (FrameStrobe != '0) begin
            strobe_cycles++;
            run++;
            if (!$onehot(FrameStrobe)) not_onehot++;
        end else begin
            run = 0;
        end
        if (run > max_run) max_run = run;
        if (!WordReady && !RESET) ready_low++;
    end

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [159:0] onehot(input int idx);
        logic [159:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Presents a word and holds WordValid high until the DUT takes it; returns #1 after the accepting edge.
    task automatic send_word(input logic [31:0] w);
        int n;
        n = 0;
        WordData  = w;
        WordValid = 1'b1;
        while (!WordReady && n < 20) begin
            @(posedge CLK); #1;
            n++;
        end
        if (!WordReady) check_eq("ready_timeout", {255'd0, WordReady}, 256'd1);
        @(posedge CLK); #1;
    endtask

    task automatic idle_bus();
        WordValid = 1'b0;
        WordData  = '0;
    endtask

    task automatic do_reset();
        idle_bus();
        RESET = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] hdr, input logic [31:0] w0, w1, w2, w3);
        send_word({16'h0000, hdr});
        send_word(w0);
        send_word(w1);
        send_word(w2);
        send_word(w3);
    endtask

    initial begin
        int s0, r0, t0, stalls, g;
        logic [31:0] fw [5];
        RESET = 1'b0;
        idle_bus();
        do_reset();

        // Reset state
        check_eq("rst_data",   FrameData,    256'd0);
        check_eq("rst_strobe", FrameStrobe,  256'd0);
        check_eq("rst_count",  FrameCount,   256'd0);
        check_eq("rst_error",  Error,        256'd0);
        check_eq("rst_active", ConfigActive, 256'd0);
        check_eq("rst_ready",  WordReady,    256'd1);

        // Basic frame: col 2, frame 3 -> bit 43
        send_word(SYNC);
        check_eq("sync_active", ConfigActive, 256'd1);
        send_frame(16'h0203, 32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004);
        idle_bus();
        check_eq("basic_strobe", FrameStrobe, onehot(43));
        check_eq("basic_data",   FrameData,
                 {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001});
        check_eq("basic_count",  FrameCount, 256'd1);
        check_eq("basic_ready",  WordReady,  256'd0);
        @(posedge CLK); #1;
        check_eq("basic_strobe_off", FrameStrobe, 256'd0);
        send_word(DESYNC);
        idle_bus();
        check_eq("desync_active", ConfigActive, 256'd0);

        // Out-of-range header, then a valid frame (col 1, frame 19 -> bit 39)
        send_word(SYNC);
        s0 = strobe_cycles;
        send_frame(16'h0800, 32'h1, 32'h2, 32'h3, 32'h4);
        idle_bus();
        repeat (2) @(posedge CLK); #1;
        check_eq("badcol_error",  Error,      256'd1);
        check_eq("badcol_count",  FrameCount, 256'd0);
        check_eq("badcol_nostrb", strobe_cycles - s0, 256'd0);
        send_frame(16'h0014, 32'h1, 32'h2, 32'h3, 32'h4);
        idle_bus();
        repeat (2) @(posedge CLK); #1;
        check_eq("badfrm_nostrb", strobe_cycles - s0, 256'd0);
        send_frame(16'h0113, 32'h11, 32'h22, 32'h33, 32'h44);
        idle_bus();
        check_eq("after_bad_strobe", FrameStrobe, onehot(39));
        check_eq("after_bad_count",  FrameCount, 256'd1);
        check_eq("error_sticky",     Error,      256'd1);

        // Words before sync are discarded
        do_reset();
        s0 = strobe_cycles;
        send_frame(16'h0203, 32'h11, 32'h22, 32'h33, 32'h44);
        idle_bus();
        repeat (3) @(posedge CLK); #1;
        check_eq("presync_nostrb",  strobe_cycles - s0, 256'd0);
        check_eq("presync_active",  ConfigActive, 256'd0);
        check_eq("presync_data",    FrameData,    256'd0);

        // Back-to-back frames with WordValid held high
        send_word(SYNC);
        check_eq("sync_clears_err", Error, 256'd0);
        s0 = strobe_cycles;
        r0 = ready_low;
        max_run = 0;
        send_frame(16'h0000, 32'h1, 32'h2, 32'h3, 32'h4);
        send_frame(16'h0713, 32'h5, 32'h6, 32'h7, 32'h8);
        check_eq("b2b_strobe", FrameStrobe, onehot(159));
        check_eq("b2b_data",   FrameData,   {32'h8, 32'h7, 32'h6, 32'h5});
        idle_bus();
        @(posedge CLK); #1;
        check_eq("b2b_strobes",   strobe_cycles - s0, 256'd2);
        check_eq("b2b_ready_low", ready_low - r0,     256'd2);
        check_eq("b2b_run",       max_run,            256'd1);
        check_eq("b2b_count",     FrameCount,         256'd2);
        send_word(DESYNC);
        idle_bus();

        // Reset after the second data word
        send_word(SYNC);
        send_word({16'h0000, 16'h0203});
        send_word(32'hA);
        send_word(32'hB);
        idle_bus();
        s0 = strobe_cycles;
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        check_eq("midrst_data",   FrameData,    256'd0);
        check_eq("midrst_strobe", FrameStrobe,  256'd0);
        check_eq("midrst_active", ConfigActive, 256'd0);
        check_eq("midrst_ready",  WordReady,    256'd1);
        check_eq("midrst_count",  FrameCount,   256'd0);
        repeat (6) @(posedge CLK); #1;
        check_eq("midrst_nostrb", strobe_cycles - s0, 256'd0);
        send_word(SYNC);
        send_frame(16'h0105, 32'h10, 32'h20, 32'h30, 32'h40);
        idle_bus();
        check_eq("postrst_strobe", FrameStrobe, onehot(25));
        check_eq("postrst_count",  FrameCount,  256'd1);

        // Random WordValid gaps: same result, strobe late by exactly the stall cycles
        @(posedge CLK); #1;
        fw[0] = 32'h0000_0203;
        fw[1] = 32'hAAAA_0001;
        fw[2] = 32'hBBBB_0002;
        fw[3] = 32'hCCCC_0003;
        fw[4] = 32'hDDDD_0004;
        t0 = cyc;
        stalls = 0;
        for (int i = 0; i < 5; i++) begin
            g = $urandom_range(0, 3);
            if (g > 0) begin
                WordValid = 1'b0;
                repeat (g) @(posedge CLK);
                #1;
                stalls += g;
            end
            send_word(fw[i]);
        end
        idle_bus();
        check_eq("stall_strobe", FrameStrobe, onehot(43));
        check_eq("stall_data",   FrameData,
                 {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001});
        check_eq("stall_timing", cyc - t0, 5 + stalls);
        check_eq("stall_count",  FrameCount, 256'd2);

        check_eq("onehot_always", not_onehot, 256'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
